// File: rtl/axi4lite_mst.sv
// AXI4-Lite initiator: turns one local read/write command into AXI4-Lite channel handshakes.
// Optional response watchdog enabled by defining AXI4LITE_MST_TIMEOUT_EN.
module axi4lite_mst #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_we,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RVALID,
    output logic                    RREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic [STRB_W-1:0]       wstrb_reg, wstrb_next;
    logic                    we_reg, we_next;
    logic                    awvalid_reg, awvalid_next;
    logic                    wvalid_reg, wvalid_next;
    logic                    bready_reg, bready_next;
    logic                    arvalid_reg, arvalid_next;
    logic                    rready_reg, rready_next;
    logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
    logic [1:0]              resp_reg, resp_next;
    logic                    timeout_hit;

`ifdef AXI4LITE_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] count_reg;

    // Counts every cycle between command acceptance and the move to DONE.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (state_reg == IDLE || state_reg == DONE) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign timeout_hit = (state_reg != IDLE) && (state_reg != DONE) &&
                         (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
    if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            we_reg      <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            rdata_reg   <= '0;
            resp_reg    <= 2'b00;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            wstrb_reg   <= wstrb_next;
            we_reg      <= we_next;
            awvalid_reg <= awvalid_next;
            wvalid_reg  <= wvalid_next;
            bready_reg  <= bready_next;
            arvalid_reg <= arvalid_next;
            rready_reg  <= rready_next;
            rdata_reg   <= rdata_next;
            resp_reg    <= resp_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        we_next      = we_reg;
        awvalid_next = awvalid_reg;
        wvalid_next  = wvalid_reg;
        bready_next  = bready_reg;
        arvalid_next = arvalid_reg;
        rready_next  = rready_reg;
        rdata_next   = rdata_reg;
        resp_next    = resp_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    addr_next    = cmd_addr;
                    wdata_next   = cmd_wdata;
                    wstrb_next   = cmd_wstrb;
                    we_next      = cmd_we;
                    awvalid_next = cmd_we;
                    wvalid_next  = cmd_we;
                    arvalid_next = !cmd_we;
                    state_next   = cmd_we ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; a channel already done counts as complete.
                if (AWREADY) awvalid_next = 1'b0;
                if (WREADY)  wvalid_next  = 1'b0;
                if ((!awvalid_reg || AWREADY) && (!wvalid_reg || WREADY)) begin
                    bready_next = 1'b1;
                    state_next  = WR_RESP;
                end else if (timeout_hit) begin
                    awvalid_next = 1'b0;
                    wvalid_next  = 1'b0;
                    resp_next    = 2'b11;
                    rdata_next   = '0;
                    state_next   = DONE;
                end
            end
            WR_RESP: begin
                if (BVALID) begin
                    resp_next   = BRESP;
                    rdata_next  = '0;
                    bready_next = 1'b0;
                    state_next  = DONE;
                end else if (timeout_hit) begin
                    bready_next = 1'b0;
                    resp_next   = 2'b11;
                    rdata_next  = '0;
                    state_next  = DONE;
                end
            end
            RD_REQ: begin
                if (ARREADY) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = RD_RESP;
                end else if (timeout_hit) begin
                    arvalid_next = 1'b0;
                    resp_next    = 2'b11;
                    rdata_next   = '0;
                    state_next   = DONE;
                end
            end
            RD_RESP: begin
                if (RVALID) begin
                    resp_next   = RRESP;
                    rdata_next  = RDATA;
                    rready_next = 1'b0;
                    state_next  = DONE;
                end else if (timeout_hit) begin
                    rready_next = 1'b0;
                    resp_next   = 2'b11;
                    rdata_next  = '0;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == DONE);
    assign rsp_we    = we_reg;
    assign rsp_rdata = rdata_reg;
    assign rsp_resp  = resp_reg;
    assign AWADDR    = addr_reg;
    assign AWVALID   = awvalid_reg;
    assign WDATA     = wdata_reg;
    assign WSTRB     = wstrb_reg;
    assign WVALID    = wvalid_reg;
    assign BREADY    = bready_reg;
    assign ARADDR    = addr_reg;
    assign ARVALID   = arvalid_reg;
    assign RREADY    = rready_reg;

endmodule

// File: tb/tb_axi4lite_mst.sv
// Bench for axi4lite_mst: directed and random commands against a delay-configurable slave,
// with expected responses taken from a word-level memory model.
module tb_axi4lite_mst;

    localparam int TO = 16;

    logic        aclk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_we;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    axi4lite_mst #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .aclk(aclk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 aclk = ~aclk;

    // Slave behaviour knobs, written only by the main sequence.
    int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] slv_bresp = 2'b00, slv_rresp = 2'b00;
    logic       b_mute = 1'b0;

    int          aw_cnt = 0, w_cnt = 0;
    logic [3:0]  slv_awaddr = '0;
    logic [31:0] slv_wdata = '0;
    logic [3:0]  slv_wstrb = '0;
    logic [31:0] slv_mem [4];

    initial begin
        AWREADY = 1'b0;
        forever begin
            @(posedge aclk); #1;
            if (AWVALID && !rst) begin
                repeat (aw_dly) begin @(posedge aclk); #1; end
                AWREADY = 1'b1;
                @(posedge aclk);
                if (AWVALID) begin slv_awaddr = AWADDR; aw_cnt++; end
                #1 AWREADY = 1'b0;
            end
        end
    end

    initial begin
        WREADY = 1'b0;
        forever begin
            @(posedge aclk); #1;
            if (WVALID && !rst) begin
                repeat (w_dly) begin @(posedge aclk); #1; end
                WREADY = 1'b1;
                @(posedge aclk);
                if (WVALID) begin slv_wdata = WDATA; slv_wstrb = WSTRB; w_cnt++; end
                #1 WREADY = 1'b0;
            end
        end
    end

    initial begin
        int seen_aw, seen_w;
        seen_aw = 0; seen_w = 0;
        BVALID = 1'b0; BRESP = 2'b00;
        for (int i = 0; i < 4; i++) slv_mem[i] = '0;
        forever begin
            @(posedge aclk); #1;
            if (b_mute) begin
                seen_aw = aw_cnt; seen_w = w_cnt;
            end else if (aw_cnt != seen_aw && w_cnt != seen_w) begin
                seen_aw = aw_cnt; seen_w = w_cnt;
                repeat (b_dly) begin @(posedge aclk); #1; end
                BVALID = 1'b1; BRESP = slv_bresp;
                do @(posedge aclk); while (!BREADY);
                if (slv_bresp == 2'b00)
                    for (int i = 0; i < 4; i++)
                        if (slv_wstrb[i]) slv_mem[slv_awaddr[3:2]][8*i +: 8] = slv_wdata[8*i +: 8];
                #1 BVALID = 1'b0; BRESP = 2'b00;
            end
        end
    end

    initial begin
        logic [3:0] a;
        logic       got;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
        forever begin
            @(posedge aclk); #1;
            if (ARVALID && !rst) begin
                repeat (ar_dly) begin @(posedge aclk); #1; end
                ARREADY = 1'b1;
                got = 1'b0; a = '0;
                @(posedge aclk);
                if (ARVALID) begin a = ARADDR; got = 1'b1; end
                #1 ARREADY = 1'b0;
                if (got) begin
                    repeat (r_dly) begin @(posedge aclk); #1; end
                    RVALID = 1'b1; RDATA = slv_mem[a[3:2]]; RRESP = slv_rresp;
                    do @(posedge aclk); while (!RREADY);
                    #1 RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
                end
            end
        end
    end

    // Bus monitor: handshake and VALID-cycle counters plus hold-until-handshake violations.
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int          awv_cyc = 0, wv_cyc = 0, arv_cyc = 0, viol = 0;
    logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
    logic [3:0]  p_awaddr = '0, p_araddr = '0, p_wstrb = '0;
    logic [31:0] p_wdata = '0;

    always @(posedge aclk) begin
        aw_hs   <= aw_hs + 32'(AWVALID && AWREADY);
        w_hs    <= w_hs + 32'(WVALID && WREADY);
        b_hs    <= b_hs + 32'(BVALID && BREADY);
        ar_hs   <= ar_hs + 32'(ARVALID && ARREADY);
        r_hs    <= r_hs + 32'(RVALID && RREADY);
        awv_cyc <= awv_cyc + 32'(AWVALID);
        wv_cyc  <= wv_cyc + 32'(WVALID);
        arv_cyc <= arv_cyc + 32'(ARVALID);
        if (!rst && ((p_aw && (AWVALID !== 1'b1 || AWADDR !== p_awaddr)) ||
                     (p_w  && (WVALID !== 1'b1 || WDATA !== p_wdata || WSTRB !== p_wstrb)) ||
                     (p_ar && (ARVALID !== 1'b1 || ARADDR !== p_araddr))))
            viol <= viol + 1;
        p_aw     <= !rst && AWVALID && !AWREADY;
        p_w      <= !rst && WVALID && !WREADY;
        p_ar     <= !rst && ARVALID && !ARREADY;
        p_awaddr <= AWADDR;
        p_wdata  <= WDATA;
        p_wstrb  <= WSTRB;
        p_araddr <= ARADDR;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          checks = 0, failures = 0;
    logic [31:0] ref_mem [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int hold);
        int          a0, w0, b0, ar0, r0, av0, wv0, arv0, n;
        logic [31:0] exp_rd;
        logic [1:0]  exp_resp;
        a0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
        av0 = awv_cyc; wv0 = wv_cyc; arv0 = arv_cyc;
        exp_resp = we ? slv_bresp : slv_rresp;
        exp_rd   = we ? 32'h0 : ref_mem[addr[3:2]];
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        @(posedge aclk); #1;
        cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = 4'($urandom); cmd_wstrb = 4'($urandom);
        chk("req_valid_latency", 32'({AWVALID, WVALID, ARVALID}), we ? 32'd6 : 32'd1);
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        n = 0;
        while (!rsp_valid && n < 300) begin @(posedge aclk); #1; n++; end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_we", 32'(rsp_we), 32'(we));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_we = 1'b0;
            @(posedge aclk); #1;
            chk("hold_rsp_stable", {rsp_valid, 27'd0, rsp_resp, 1'b0, rsp_we} ^ rsp_rdata,
                {1'b1, 27'd0, exp_resp, 1'b0, we} ^ exp_rd);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge aclk); #1;
        rsp_ready = 1'b0;
        chk("rsp_released", 32'({rsp_valid, cmd_ready}), 32'd1);
        repeat (2) @(posedge aclk);
        #1;
        chk("aw_handshakes", 32'(aw_hs - a0), 32'(we));
        chk("w_handshakes", 32'(w_hs - w0), 32'(we));
        chk("b_handshakes", 32'(b_hs - b0), 32'(we));
        chk("ar_handshakes", 32'(ar_hs - ar0), 32'(!we));
        chk("r_handshakes", 32'(r_hs - r0), 32'(!we));
        chk("awvalid_cycles", 32'(awv_cyc - av0), we ? 32'(aw_dly + 1) : 32'd0);
        chk("wvalid_cycles", 32'(wv_cyc - wv0), we ? 32'(w_dly + 1) : 32'd0);
        chk("arvalid_cycles", 32'(arv_cyc - arv0), we ? 32'd0 : 32'(ar_dly + 1));
        if (we && exp_resp == 2'b00)
            for (int i = 0; i < 4; i++)
                if (ws[i]) ref_mem[addr[3:2]][8*i +: 8] = wd[8*i +: 8];
        $display("txn we=%0d addr=%h wdata=%h wstrb=%h resp=%0d rdata=%h checks=%0d failures=%0d",
                 we, addr, wd, ws, rsp_resp, rsp_rdata, checks, failures);
    endtask

    task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_axi_ctl", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}), 32'd0);
        chk("reset_payload", 32'(AWADDR) | WDATA | 32'(WSTRB) | rsp_rdata | 32'(rsp_resp), 32'd0);
        rst = 1'b0;
        @(posedge aclk); #1;

        // Basic write then read-back.
        set_dly(0, 0, 0, 0, 0);
        run_txn(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 0);
        run_txn(1'b0, 4'h4, 32'h0, 4'h0, 0);
        // W channel lagging AW by three cycles.
        set_dly(0, 3, 0, 0, 0);
        run_txn(1'b1, 4'h0, 32'hA5A55A5A, 4'hF, 0);
        // Late read data.
        set_dly(0, 0, 0, 0, 0);
        run_txn(1'b1, 4'hC, 32'h12345678, 4'hF, 0);
        set_dly(0, 0, 0, 1, 2);
        run_txn(1'b0, 4'hC, 32'h0, 4'h0, 0);
        // SLVERR passes through and the block keeps accepting commands.
        set_dly(2, 0, 1, 0, 0);
        slv_bresp = 2'b10;
        run_txn(1'b1, 4'h8, 32'hFFFFFFFF, 4'hF, 0);
        slv_bresp = 2'b00;
        run_txn(1'b0, 4'h8, 32'h0, 4'h0, 0);
        // Consumer stalls the response for five cycles.
        run_txn(1'b1, 4'h8, 32'hCAFEF00D, 4'h5, 5);

        // Reset while waiting for BVALID.
        b_mute = 1'b1;
        set_dly(0, 0, 0, 0, 0);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'hF;
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!BREADY && n < 50) begin @(posedge aclk); #1; n++; end
        chk("wr_resp_reached", 32'(BREADY), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("midrst_axi_ctl", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge aclk); #1;
        rst = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("postrst_idle", 32'({rsp_valid, cmd_ready}), 32'd1);
        b_mute = 1'b0;
        run_txn(1'b0, 4'h4, 32'h0, 4'h0, 0);

`ifdef AXI4LITE_MST_TIMEOUT_EN
        // Silent slave: response code 11 exactly TO cycles after WR_REQ entry.
        b_mute = 1'b1;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'h11111111; cmd_wstrb = 4'hF;
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        repeat (TO - 1) @(posedge aclk);
        #1;
        chk("timeout_not_early", 32'(rsp_valid), 32'd0);
        @(posedge aclk); #1;
        chk("timeout_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("timeout_rsp_resp", 32'(rsp_resp), 32'd3);
        chk("timeout_rsp_rdata", rsp_rdata, 32'd0);
        chk("timeout_axi_ctl", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 32'd0);
        rsp_ready = 1'b1;
        @(posedge aclk); #1;
        rsp_ready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        b_mute = 1'b0;
`endif

        // Random traffic.
        for (int t = 0; t < 30; t++) begin
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            slv_bresp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            slv_rresp = 2'($urandom_range(0, 3));
            run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3) << 2), $urandom,
                    4'($urandom), $urandom_range(0, 2));
        end

        chk("protocol_hold_violations", 32'(viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
